// File: rtl/pito_prog_loader_if.sv
// Host byte stream and memory/core programming bus of pito_prog_loader.
// slave modport: the loader itself. master modport: host/core side.
interface pito_prog_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        ld_in_data;
  logic              ld_in_valid;
  logic              ld_in_ready;
  logic [ADDR_W-1:0] ld_mem_addr;
  logic [31:0]       ld_mem_data;
  logic              ld_imem_w_en;
  logic              ld_dmem_w_en;
  logic              ld_program;
  logic              ld_core_rst_n;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_err;

  modport slave (
    input  ld_in_data, ld_in_valid,
    output ld_in_ready, ld_mem_addr, ld_mem_data, ld_imem_w_en, ld_dmem_w_en,
           ld_program, ld_core_rst_n, ld_busy, ld_done, ld_err
  );

  modport master (
    output ld_in_data, ld_in_valid,
    input  ld_in_ready, ld_mem_addr, ld_mem_data, ld_imem_w_en, ld_dmem_w_en,
           ld_program, ld_core_rst_n, ld_busy, ld_done, ld_err
  );
endinterface

// File: rtl/pito_prog_loader.sv
// pito_prog_loader: parses a host command byte stream and programs the rv32
// core's imem/dmem through its io ports, holding the core in reset while
// loading and releasing it on CMD_RUN.
// Optional: define PITO_LOADER_CKSUM_EN to require a trailing XOR checksum
// byte after every non-empty load.
module pito_prog_loader #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [7:0]  CMD_IMEM = 8'hA5,
  parameter logic [7:0]  CMD_DMEM = 8'h5A,
  parameter logic [7:0]  CMD_RUN  = 8'h0F,
  parameter logic [7:0]  CMD_HALT = 8'hC3
) (
  input logic              rv32_io_clk,
  input logic              rv32_io_rst_n,
  pito_prog_loader_if.slave ld
);

  localparam int unsigned REM_W     = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
`ifdef PITO_LOADER_CKSUM_EN
    CKSUM,
`endif
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic              target_q, target_d;   // 1: dmem, 0: imem
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [REM_W-1:0]  rem_q, rem_d;         // words still to write
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       wbuf_q, wbuf_d;
`ifdef PITO_LOADER_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              imem_q, imem_d;
  logic              dmem_q, dmem_d;
  logic              program_q, program_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [7:0]        b;
  logic [15:0]       cnt_full;

  assign xfer     = ld.ld_in_valid & in_ready_q;
  assign b        = ld.ld_in_data;
  assign cnt_full = {b, cnt_lo_q};

  assign ld.ld_in_ready   = in_ready_q;
  assign ld.ld_mem_addr   = addr_q;
  assign ld.ld_mem_data   = data_q;
  assign ld.ld_imem_w_en  = imem_q;
  assign ld.ld_dmem_w_en  = dmem_q;
  assign ld.ld_program    = program_q;
  assign ld.ld_core_rst_n = core_rst_n_q;
  assign ld.ld_busy       = busy_q;
  assign ld.ld_done       = done_q;
  assign ld.ld_err        = err_q;

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cnt_lo_d   = cnt_lo_q;
    rem_d      = rem_q;
    widx_d     = widx_q;
    bidx_d     = bidx_q;
    wbuf_d     = wbuf_q;
`ifdef PITO_LOADER_CKSUM_EN
    cksum_d    = cksum_q;
`endif
    in_ready_d = 1'b1;
    addr_d     = addr_q;
    data_d     = data_q;
    imem_d     = 1'b0;
    dmem_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (b == CMD_IMEM || b == CMD_DMEM) begin
            target_d = (b == CMD_DMEM);
            err_d    = 1'b0;
            state_d  = CNT_LO;
          end else if (b == CMD_RUN) begin
            if (!err_q) state_d = RUN;
          end else if (b != CMD_HALT) begin
            err_d = 1'b1;
          end
        end
      end
      CNT_LO: begin
        if (xfer) begin
          cnt_lo_d = b;
          state_d  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          if (cnt_full == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if ({1'b0, cnt_full} > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d   = REM_W'(cnt_full);
            widx_d  = '0;
            bidx_d  = '0;
`ifdef PITO_LOADER_CKSUM_EN
            cksum_d = '0;
`endif
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef PITO_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ b;
`endif
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: wbuf_d[7:0]   = b;
            2'd1: wbuf_d[15:8]  = b;
            2'd2: wbuf_d[23:16] = b;
            default: begin
              // Word complete: the write is issued from the registered
              // outputs while the next word's bytes are already arriving.
              data_d = {b, wbuf_q};
              addr_d = widx_q;
              imem_d = ~target_q;
              dmem_d = target_q;
              widx_d = widx_q + 1'b1;
              rem_d  = rem_q - 1'b1;
              if (rem_q == REM_W'(1)) begin
`ifdef PITO_LOADER_CKSUM_EN
                state_d = CKSUM;
`else
                done_d  = 1'b1;
                state_d = IDLE;
`endif
              end
            end
          endcase
        end
      end
`ifdef PITO_LOADER_CKSUM_EN
      CKSUM: begin
        if (xfer) begin
          if (b == cksum_q) done_d = 1'b1;
          else              err_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      RUN: begin
        if (xfer && b == CMD_HALT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d       = (state_d != IDLE) && (state_d != RUN);
    core_rst_n_d = (state_d == RUN);
    program_d    = (state_d != RUN);
  end

  // State and output registers; async reset discards any partial word.
  always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
    if (!rv32_io_rst_n) begin
      state_q      <= IDLE;
      target_q     <= 1'b0;
      cnt_lo_q     <= '0;
      rem_q        <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      wbuf_q       <= '0;
`ifdef PITO_LOADER_CKSUM_EN
      cksum_q      <= '0;
`endif
      in_ready_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      imem_q       <= 1'b0;
      dmem_q       <= 1'b0;
      program_q    <= 1'b1;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_lo_q     <= cnt_lo_d;
      rem_q        <= rem_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      wbuf_q       <= wbuf_d;
`ifdef PITO_LOADER_CKSUM_EN
      cksum_q      <= cksum_d;
`endif
      in_ready_q   <= in_ready_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      imem_q       <= imem_d;
      dmem_q       <= dmem_d;
      program_q    <= program_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule
